// File: rtl/rf_dump.sv
// rf_dump: debug readout engine for the register file.
// Sweeps all registers (or reads one) through a spare read port and emits
// each value as an indexed valid/ready stream, keeping an XOR checksum of
// every accepted word.
module rf_dump #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] sel_in,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [ADDR_W-1:0]   last_idx_q, last_idx_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rf_addr_q   <= '0;
      last_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      rf_addr_q   <= rf_addr_d;
      last_idx_q  <= last_idx_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      checksum_q  <= checksum_d;
    end
  end

  // Next-state logic: everything holds unless the current state updates it.
  always_comb begin
    state_d     = state_q;
    rf_addr_d   = rf_addr_q;
    last_idx_d  = last_idx_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    checksum_d  = checksum_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rf_addr_d  = mode ? sel_in : '0;
          last_idx_d = mode ? sel_in : LAST_IDX;
          checksum_d = '0;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        out_data_d  = rf_data;
        out_idx_d   = rf_addr_q;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_valid_q && out_ready) begin
          checksum_d  = checksum_q ^ out_data_q;
          out_valid_d = 1'b0;
          if (rf_addr_q == last_idx_q) begin
            state_d = S_DONE;
          end else begin
            rf_addr_d = rf_addr_q + ADDR_W'(1);
            state_d   = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rf_addr   = rf_addr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign checksum  = checksum_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_rf_dump.sv
// Directed testbench for rf_dump with a behavioural register-file model.
module tb_rf_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  sel_in = '0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] rf [32];
  assign rf_data = rf[rf_addr];

  rf_dump #(.NREGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sel_in(sel_in),
    .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the most recent transfer.
  logic [4:0]  got_idx [64];
  logic [31:0] got_data [64];
  logic [31:0] exp_d [32];
  logic [31:0] cks_at_done;
  int nw, done_edge, first_valid_edge, stable_err, edges;
  bit timeout, rst_hit, busy_e1;

  task automatic preload_std();
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'(i) * 32'h01010101;
      exp_d[i] = 32'(i) * 32'h01010101;
    end
  endtask

  // Drive one transfer from a negedge and record every accepted word.
  task automatic xfer(input logic m, input logic [4:0] sel, input bit stall,
                      input bit spam, input int rst_idx, input bit wr3);
    logic [4:0]  sv_idx;
    logic [31:0] sv_data;
    bit prev_stall;
    nw = 0; done_edge = -1; first_valid_edge = -1; stable_err = 0; edges = 0;
    timeout = 0; rst_hit = 0; busy_e1 = 0; prev_stall = 0;
    sv_idx = '0; sv_data = '0;
    start = 1'b1; mode = m; sel_in = sel;
    for (int cyc = 0; cyc < 500; cyc++) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_idx >= 0 && out_valid && out_idx == 5'(rst_idx)) begin
        out_ready = 1'b0;
        rst_hit = 1;
        return;
      end
      if (wr3 && out_valid && out_idx == 5'd3) begin
        rf[5] = 32'h12345678;
        rf[3] = 32'hBAD0BAD0;
      end
      if (prev_stall && (!out_valid || out_idx !== sv_idx || out_data !== sv_data))
        stable_err++;
      if (out_valid && out_ready && nw < 64) begin
        got_idx[nw] = out_idx; got_data[nw] = out_data; nw++;
      end
      prev_stall = out_valid && !out_ready;
      sv_idx = out_idx; sv_data = out_data;
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = spam;
      if (edges == 1) busy_e1 = busy;
      if (out_valid && first_valid_edge < 0) first_valid_edge = edges;
      if (done) begin
        done_edge = edges;
        cks_at_done = checksum;
        return;
      end
    end
    timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if ({out_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b want=000", {out_valid, busy, done}); end
    n_tests++; if (rf_addr !== 5'd0 || out_idx !== 5'd0) begin n_fail++; $display("FAIL reset_addr got rf_addr=%0d out_idx=%0d want 0", rf_addr, out_idx); end
    n_tests++; if (out_data !== 32'h0 || checksum !== 32'h0) begin n_fail++; $display("FAIL reset_data got data=%h cks=%h want 0", out_data, checksum); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_start got busy=%b valid=%b want 0", busy, out_valid); end
  endtask

  task automatic test_full_sweep();
    int errs;
    logic [31:0] x;
    preload_std();
    x = '0;
    for (int i = 0; i < 32; i++) x ^= exp_d[i];
    xfer(1'b0, 5'd0, 1'b0, 1'b0, -1, 1'b0);
    errs = 0;
    for (int i = 0; i < 32; i++) if (got_idx[i] !== 5'(i) || got_data[i] !== exp_d[i]) errs++;
    n_tests++; if (timeout) begin n_fail++; $display("FAIL sweep_timeout got=timeout want=done"); end
    n_tests++; if (nw != 32) begin n_fail++; $display("FAIL sweep_count got=%0d want=32", nw); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL sweep_order got=%0d bad words want=0", errs); end
    n_tests++; if (done_edge != 65) begin n_fail++; $display("FAIL sweep_latency got=%0d want=65", done_edge); end
    n_tests++; if (first_valid_edge != 2) begin n_fail++; $display("FAIL first_valid got=%0d want=2", first_valid_edge); end
    n_tests++; if (busy_e1 !== 1'b1) begin n_fail++; $display("FAIL busy_rise got=%b want=1", busy_e1); end
    n_tests++; if (cks_at_done !== x) begin n_fail++; $display("FAIL sweep_cks got=%h want=%h", cks_at_done, x); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_done got=%b want=1", busy); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy); end
    n_tests++; if (checksum !== x) begin n_fail++; $display("FAIL cks_hold got=%h want=%h", checksum, x); end
    n_tests++; if (rf_addr !== 5'd31) begin n_fail++; $display("FAIL addr_hold got=%0d want=31", rf_addr); end
  endtask

  task automatic test_backpressure();
    int errs;
    preload_std();
    xfer(1'b0, 5'd0, 1'b1, 1'b0, -1, 1'b0);
    errs = 0;
    for (int i = 0; i < 32; i++) if (got_idx[i] !== 5'(i) || got_data[i] !== exp_d[i]) errs++;
    n_tests++; if (timeout || nw != 32) begin n_fail++; $display("FAIL bp_count got=%0d timeout=%0d want=32", nw, timeout); end
    n_tests++; if (errs != 0) begin n_fail++; $display("FAIL bp_order got=%0d bad words want=0", errs); end
    n_tests++; if (stable_err != 0) begin n_fail++; $display("FAIL bp_stable got=%0d changes want=0", stable_err); end
    n_tests++; if (cks_at_done !== 32'h0) begin n_fail++; $display("FAIL bp_cks got=%h want=00000000", cks_at_done); end
    @(negedge clk);
  endtask

  task automatic test_single();
    preload_std();
    rf[17] = 32'hDEADBEEF;
    xfer(1'b1, 5'd17, 1'b0, 1'b0, -1, 1'b0);
    n_tests++; if (nw != 1) begin n_fail++; $display("FAIL single_count got=%0d want=1", nw); end
    n_tests++; if (got_idx[0] !== 5'd17 || got_data[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_word got idx=%0d data=%h want 17 deadbeef", got_idx[0], got_data[0]); end
    n_tests++; if (done_edge != 3) begin n_fail++; $display("FAIL single_latency got=%0d want=3", done_edge); end
    n_tests++; if (cks_at_done !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_cks got=%h want=deadbeef", cks_at_done); end
    @(negedge clk);
  endtask

  task automatic test_start_spam();
    for (int i = 0; i < 32; i++) rf[i] = 32'h1 << i;
    xfer(1'b0, 5'd0, 1'b0, 1'b1, -1, 1'b0);
    n_tests++; if (nw != 32 || done_edge != 65) begin n_fail++; $display("FAIL spam_sweep got words=%0d done_edge=%0d want 32 65", nw, done_edge); end
    n_tests++; if (cks_at_done !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL spam_cks got=%h want=ffffffff", cks_at_done); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL spam_idle got busy=%b want=0", busy); end
    xfer(1'b0, 5'd0, 1'b0, 1'b0, -1, 1'b0);
    n_tests++; if (nw != 32 || cks_at_done !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL restart_cks got words=%0d cks=%h want 32 ffffffff", nw, cks_at_done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad;
    preload_std();
    xfer(1'b0, 5'd0, 1'b0, 1'b0, 10, 1'b0);
    n_tests++; if (!rst_hit || out_idx !== 5'd10) begin n_fail++; $display("FAIL rstmid_reach got hit=%0d idx=%0d want 1 10", rst_hit, out_idx); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if ({out_valid, busy, done} !== 3'b000 || out_data !== 32'h0 || out_idx !== 5'd0) begin n_fail++; $display("FAIL rstmid_out got v/b/d=%b data=%h idx=%0d want 0", {out_valid, busy, done}, out_data, out_idx); end
    n_tests++; if (rf_addr !== 5'd0 || checksum !== 32'h0) begin n_fail++; $display("FAIL rstmid_state got addr=%0d cks=%h want 0", rf_addr, checksum); end
    #2 rst = 1'b0;
    bad = 0;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || done || busy) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet got=%0d active cycles want=0", bad); end
    xfer(1'b0, 5'd0, 1'b0, 1'b0, -1, 1'b0);
    n_tests++; if (nw != 32 || done_edge != 65 || got_data[31] !== 32'h1F1F1F1F) begin n_fail++; $display("FAIL rstmid_resweep got words=%0d edge=%0d last=%h want 32 65 1f1f1f1f", nw, done_edge, got_data[31]); end
    @(negedge clk);
  endtask

  task automatic test_rf_write();
    int errs;
    logic [31:0] x;
    preload_std();
    exp_d[5] = 32'h12345678;
    x = '0;
    for (int i = 0; i < 32; i++) x ^= exp_d[i];
    xfer(1'b0, 5'd0, 1'b0, 1'b0, -1, 1'b1);
    errs = 0;
    for (int i = 0; i < 32; i++) if (got_idx[i] !== 5'(i) || got_data[i] !== exp_d[i]) errs++;
    n_tests++; if (got_data[3] !== 32'h03030303) begin n_fail++; $display("FAIL wr_word3 got=%h want=03030303", got_data[3]); end
    n_tests++; if (got_data[5] !== 32'h12345678) begin n_fail++; $display("FAIL wr_word5 got=%h want=12345678", got_data[5]); end
    n_tests++; if (nw != 32 || errs != 0) begin n_fail++; $display("FAIL wr_sweep got words=%0d bad=%0d want 32 0", nw, errs); end
    n_tests++; if (cks_at_done !== x) begin n_fail++; $display("FAIL wr_cks got=%h want=%h", cks_at_done, x); end
    @(negedge clk);
  endtask

  initial begin
    preload_std();
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_single();
    test_start_spam();
    test_reset_mid();
    test_rf_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
